// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle core: opcodes, trap codes, FSM states
// and instruction field slicing helpers.
package cpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_BC   = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_MEMADR, S_MEMRD,
    S_MEMWB, S_MEMWR, S_BRANCH, S_JUMP, S_HALT, S_TRAP
  } state_t;

  function automatic logic [3:0] f_op(input logic [15:0] ir);
    return ir[15:12];
  endfunction

  function automatic logic [2:0] f_rd(input logic [15:0] ir);
    return ir[11:9];
  endfunction

  function automatic logic [2:0] f_rs(input logic [15:0] ir);
    return ir[8:6];
  endfunction

  function automatic logic [2:0] f_rt(input logic [15:0] ir);
    return ir[5:3];
  endfunction

  function automatic logic [5:0] f_imm6(input logic [15:0] ir);
    return ir[5:0];
  endfunction

  function automatic logic [11:0] f_tgt12(input logic [15:0] ir);
    return ir[11:0];
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Eight-entry register file, two combinational read ports, one synchronous
// write port; r0 always reads zero and ignores writes.
module regfile_2r1w #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [2:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [2:0]       raddr1,
  input  logic [2:0]       raddr2,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2
);

  logic [WIDTH-1:0] regs [8];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (we && waddr != 3'd0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 3'd0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == 3'd0) ? '0 : regs[raddr2];

endmodule

// File: rtl/multicycle_core_ws.sv
// Parametrised multicycle CPU core with a req/ready memory port that tolerates
// wait states, a HALT state, and sticky illegal-opcode / bus-timeout traps.
module multicycle_core_ws
  import cpu_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               MAX_WAIT = 255
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] addr,
  output logic [WIDTH-1:0] writedata,
  output logic             memreq,
  output logic             memwrite,
  input  logic [WIDTH-1:0] readdata,
  input  logic             memready,
  output logic             halted,
  output logic [1:0]       trap
);

  localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t state, next_state;
  logic [WIDTH-1:0] pc, pc_n;
  logic [15:0]      ir;
  logic [WIDTH-1:0] a, b, target, mdr;
  logic [WIDTH:0]   alu_res, alu_n;
  logic             c_flag, z_flag;
  logic [CW-1:0]    wait_cnt;
  logic             timeout;
  logic             req_n, we_n;
  logic [WIDTH-1:0] addr_n, wd_n;
  logic [1:0]       trap_n;

  logic [3:0]       op;
  logic [2:0]       rd, rs, ra2;
  logic [WIDTH-1:0] imm_sx, tgt_zx, rdata1, rdata2, rf_wdata;
  logic             rf_we;

  assign op     = f_op(ir);
  assign rd     = f_rd(ir);
  assign rs     = f_rs(ir);
  assign imm_sx = {{(WIDTH-6){ir[5]}}, f_imm6(ir)};
  assign tgt_zx = {{(WIDTH-12){1'b0}}, f_tgt12(ir)};
  // BEQ compares rd with rs and SW stores rd, so port 2 reads rd for those.
  assign ra2    = (op == OP_SW || op == OP_BEQ) ? rd : f_rt(ir);

  assign rf_we    = (state == S_ALUWB) || (state == S_MEMWB);
  assign rf_wdata = (state == S_MEMWB) ? mdr : alu_res[WIDTH-1:0];
  assign halted   = (state == S_HALT);

  assign timeout = (MAX_WAIT != 0) && memreq && !memready &&
                   (wait_cnt == CW'(MAX_WAIT - 1));

  regfile_2r1w #(.WIDTH(WIDTH)) u_rf (
    .clk    (clk),
    .reset  (reset),
    .we     (rf_we),
    .waddr  (rd),
    .wdata  (rf_wdata),
    .raddr1 (rs),
    .raddr2 (ra2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  always_comb begin
    alu_n = '0;
    case (op)
      OP_ADD:  alu_n = {1'b0, a} + {1'b0, b};
      OP_SUB:  alu_n = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
      OP_AND:  alu_n = {1'b0, a & b};
      OP_OR:   alu_n = {1'b0, a | b};
      OP_ADDI: alu_n = {1'b0, a} + {1'b0, imm_sx};
      default: alu_n = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= next_state;
  end

  // Memory-port outputs are computed as next values so they stay registered
  // and hold steady for the whole duration of a wait.
  always_comb begin
    next_state = state;
    pc_n       = pc;
    req_n      = memreq;
    addr_n     = addr;
    we_n       = memwrite;
    wd_n       = writedata;
    trap_n     = trap;
    case (state)
      S_FETCH: begin
        if (!memreq) begin
          req_n  = 1'b1;
          addr_n = pc;
          we_n   = 1'b0;
        end else if (memready) begin
          req_n      = 1'b0;
          pc_n       = pc + ONE;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: next_state = S_EXEC;
          OP_LW, OP_SW:                           next_state = S_MEMADR;
          OP_BEQ, OP_BC:                          next_state = S_BRANCH;
          OP_JMP:                                 next_state = S_JUMP;
          OP_HALT:                                next_state = S_HALT;
          default:                                next_state = S_TRAP;
        endcase
      end
      S_EXEC: next_state = S_ALUWB;
      S_ALUWB, S_MEMWB: begin
        next_state = S_FETCH;
        req_n      = 1'b1;
        addr_n     = pc;
        we_n       = 1'b0;
      end
      S_MEMADR: begin
        next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
        req_n      = 1'b1;
        addr_n     = a + imm_sx;
        we_n       = (op == OP_SW);
        wd_n       = b;
      end
      S_MEMRD: begin
        if (memready) begin
          req_n      = 1'b0;
          next_state = S_MEMWB;
        end
      end
      S_MEMWR: begin
        if (memready) begin
          next_state = S_FETCH;
          addr_n     = pc;
          we_n       = 1'b0;
        end
      end
      S_BRANCH: begin
        if ((op == OP_BEQ && a == b) || (op == OP_BC && c_flag)) pc_n = target;
        next_state = S_FETCH;
        req_n      = 1'b1;
        addr_n     = pc_n;
        we_n       = 1'b0;
      end
      S_JUMP: begin
        pc_n       = tgt_zx;
        next_state = S_FETCH;
        req_n      = 1'b1;
        addr_n     = tgt_zx;
        we_n       = 1'b0;
      end
      S_HALT: begin
        req_n = 1'b0;
        we_n  = 1'b0;
      end
      S_TRAP: begin
        trap_n     = TRAP_ILLEGAL;
        next_state = S_HALT;
        req_n      = 1'b0;
        we_n       = 1'b0;
      end
      default: next_state = S_FETCH;
    endcase
    // An expired access is abandoned outright, before any side effect lands.
    if (timeout) begin
      next_state = S_HALT;
      pc_n       = pc;
      req_n      = 1'b0;
      we_n       = 1'b0;
      trap_n     = TRAP_TIMEOUT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc        <= RESET_PC;
      ir        <= '0;
      a         <= '0;
      b         <= '0;
      target    <= '0;
      mdr       <= '0;
      alu_res   <= '0;
      c_flag    <= 1'b0;
      z_flag    <= 1'b0;
      wait_cnt  <= '0;
      memreq    <= 1'b0;
      addr      <= '0;
      memwrite  <= 1'b0;
      writedata <= '0;
      trap      <= TRAP_NONE;
    end else begin
      pc        <= pc_n;
      memreq    <= req_n;
      addr      <= addr_n;
      memwrite  <= we_n;
      writedata <= wd_n;
      trap      <= trap_n;
      wait_cnt  <= (memreq && !memready && !timeout) ? wait_cnt + CW'(1) : '0;
      case (state)
        S_FETCH:  if (memreq && memready) ir <= readdata[15:0];
        S_DECODE: begin
          a      <= rdata1;
          b      <= rdata2;
          target <= pc + imm_sx;
        end
        S_EXEC:   alu_res <= alu_n;
        S_ALUWB: begin
          z_flag <= (alu_res[WIDTH-1:0] == '0);
          if (op == OP_ADD || op == OP_SUB || op == OP_ADDI) c_flag <= alu_res[WIDTH];
        end
        S_MEMRD:  if (memready) mdr <= readdata;
        default: ;
      endcase
    end
  end

endmodule
